// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin byte scheduler feeding one uart_tx
// Optional transmitter watchdog: define TX_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int MAX_BURST   = 8,
    parameter int WDOG_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       a_ovf,
    output logic       b_ovf,
    output logic       wdog_err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    if (AW < 1 || DEPTH != (1 << AW)) begin : g_bad_depth
        $error("DEPTH must be a power of two equal to 2**AW, at least 2");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be within 1..255");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    logic [7:0] a_mem_q [DEPTH];
    logic [7:0] b_mem_q [DEPTH];
    logic [AW:0] a_wp_q, a_rp_q, b_wp_q, b_rp_q;
    logic a_empty, a_full, a_wr, a_pop, a_ovf_q;
    logic b_empty, b_full, b_wr, b_pop, b_ovf_q;
    logic [7:0] a_head, b_head;

    state_t     state_q, state_d;
    logic       owner_b_q, owner_b_d;
    logic       last_b_q, last_b_d;
    logic [7:0] burst_q, burst_d;
    logic [7:0] data_q, data_d;
    logic [1:0] grant_q, grant_d;
    logic       do_pop, pop_b, own_ne, oth_ne;

    // Wrap bit differs while the index matches: every slot holds an unread byte.
    assign a_empty = (a_wp_q == a_rp_q);
    assign a_full  = (a_wp_q[AW] != a_rp_q[AW]) && (a_wp_q[AW-1:0] == a_rp_q[AW-1:0]);
    assign b_empty = (b_wp_q == b_rp_q);
    assign b_full  = (b_wp_q[AW] != b_rp_q[AW]) && (b_wp_q[AW-1:0] == b_rp_q[AW-1:0]);
    assign a_wr    = a_valid && (!a_full || a_pop);
    assign b_wr    = b_valid && (!b_full || b_pop);
    assign a_head  = a_mem_q[a_rp_q[AW-1:0]];
    assign b_head  = b_mem_q[b_rp_q[AW-1:0]];
    assign own_ne  = owner_b_q ? !b_empty : !a_empty;
    assign oth_ne  = owner_b_q ? !a_empty : !b_empty;

    always_ff @(posedge clk) begin
        if (a_wr) a_mem_q[a_wp_q[AW-1:0]] <= a_data;
        if (b_wr) b_mem_q[b_wp_q[AW-1:0]] <= b_data;
    end

`ifdef TX_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          wdog_q, wdog_d;
`endif

    always_comb begin
        state_d   = state_q;
        owner_b_d = owner_b_q;
        last_b_d  = last_b_q;
        burst_d   = burst_q;
        data_d    = data_q;
        grant_d   = grant_q;
        do_pop    = 1'b0;
        pop_b     = 1'b0;
        a_pop     = 1'b0;
        b_pop     = 1'b0;
`ifdef TX_WATCHDOG_EN
        wcnt_d    = wcnt_q;
        wdog_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!a_empty || !b_empty) begin
                    do_pop  = 1'b1;
                    pop_b   = (!a_empty && !b_empty) ? !last_b_q : a_empty;
                    burst_d = 8'd1;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
`ifdef TX_WATCHDOG_EN
                wcnt_d  = WW'(1);
`endif
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (own_ne && (burst_q < MAX_B || !oth_ne)) begin
                        do_pop  = 1'b1;
                        pop_b   = owner_b_q;
                        burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
                    end else if (oth_ne) begin
                        do_pop   = 1'b1;
                        pop_b    = !owner_b_q;
                        last_b_d = owner_b_q;
                        burst_d  = 8'd1;
                    end else begin
                        grant_d  = 2'b00;
                        last_b_d = owner_b_q;
                        state_d  = S_IDLE;
                    end
                end
`ifdef TX_WATCHDOG_EN
                else if (wcnt_q == WDOG_LAST) begin
                    wdog_d   = 1'b1;
                    grant_d  = 2'b00;
                    last_b_d = owner_b_q;
                    state_d  = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (do_pop) begin
            a_pop     = !pop_b;
            b_pop     = pop_b;
            data_d    = pop_b ? b_head : a_head;
            grant_d   = pop_b ? 2'b10 : 2'b01;
            owner_b_d = pop_b;
            state_d   = S_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wp_q    <= '0;
            a_rp_q    <= '0;
            b_wp_q    <= '0;
            b_rp_q    <= '0;
            a_ovf_q   <= 1'b0;
            b_ovf_q   <= 1'b0;
            state_q   <= S_IDLE;
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            burst_q   <= 8'd0;
            data_q    <= 8'h00;
            grant_q   <= 2'b00;
        end else begin
            if (a_wr)  a_wp_q <= a_wp_q + 1'b1;
            if (a_pop) a_rp_q <= a_rp_q + 1'b1;
            if (b_wr)  b_wp_q <= b_wp_q + 1'b1;
            if (b_pop) b_rp_q <= b_rp_q + 1'b1;
            a_ovf_q   <= a_valid && a_full && !a_pop;
            b_ovf_q   <= b_valid && b_full && !b_pop;
            state_q   <= state_d;
            owner_b_q <= owner_b_d;
            last_b_q  <= last_b_d;
            burst_q   <= burst_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
        end
    end

`ifdef TX_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wdog_q <= wdog_d;
        end
    end
    assign wdog_err = wdog_q;
`else
    assign wdog_err = 1'b0;
`endif

    assign tx_en   = (state_q == S_LOAD);
    assign tx_data = data_q;
    assign grant   = grant_q;
    assign a_ovf   = a_ovf_q;
    assign b_ovf   = b_ovf_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_en, a_ovf, b_ovf, wdog_err;
    logic [7:0] tx_data;
    logic [1:0] grant;

    uart_tx_arbiter #(.DEPTH(16), .AW(4), .MAX_BURST(8), .WDOG_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .b_data(b_data), .b_valid(b_valid),
        .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done), .grant(grant),
        .a_ovf(a_ovf), .b_ovf(b_ovf), .wdog_err(wdog_err)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] grant;
        int         at_cyc;
        bit         b2b;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0, failures = 0, cyc = 0;
    int         done_delay = 3, mcnt = 0, last_done_cyc = -100;
    bit         done_hold = 1'b0, busy = 1'b0;
    int         a_ovf_cnt = 0, b_ovf_cnt = 0, wdog_cnt = 0, txen_cnt = 0;
    int         first_ovf_cyc = -1, first_wdog_cyc = -1;
    logic [7:0] cap = 8'h00;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] g, input int at, input bit b2b);
        exp_t e;
        e.data = d; e.grant = g; e.at_cyc = at; e.b2b = b2b;
        expq.push_back(e);
    endtask

    task automatic drive(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd);
        @(posedge clk); #1;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expq.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (expq.size() == 0 && grant == 2'b00 && !busy) break;
        end
        check({name, "_left"}, expq.size(), 0);
        check({name, "_grant_idle"}, {30'd0, grant}, 0);
    endtask

    // Transmitter model: tx_done a programmable number of cycles after tx_en.
    initial forever begin
        @(negedge clk);
        tx_done = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
        end else if (tx_en) begin
            busy = 1'b1;
            mcnt = 0;
        end else if (busy) begin
            mcnt++;
            if (mcnt >= done_delay && !done_hold) begin
                tx_done = 1'b1;
                busy = 1'b0;
                last_done_cyc = cyc;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_en and watches data stability.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (a_ovf) begin a_ovf_cnt++; if (first_ovf_cyc < 0) first_ovf_cyc = cyc; end
                if (b_ovf) b_ovf_cnt++;
                if (wdog_err) begin wdog_cnt++; if (first_wdog_cyc < 0) first_wdog_cyc = cyc; end
                if (tx_en) begin
                    txen_cnt++;
                    cap = tx_data;
                    if (expq.size() == 0) begin
                        check("unexpected_tx_en", {24'd0, tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = expq.pop_front();
                        check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
                        check("grant", {30'd0, grant}, {30'd0, e.grant});
                        if (e.at_cyc >= 0) check("first_latency", cyc, e.at_cyc);
                        if (e.b2b) check("b2b_latency", cyc, last_done_cyc + 1);
                    end
                end else if (grant != 2'b00) begin
                    check("tx_data_stable", {24'd0, tx_data}, {24'd0, cap});
                end
            end
        end
    end

    initial begin : stim
        int n, base;
        // Reset values
        @(posedge clk); #1;
        check("rst_tx_en", {31'd0, tx_en}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_grant", {30'd0, grant}, 0);
        check("rst_a_ovf", {31'd0, a_ovf}, 0);
        check("rst_b_ovf", {31'd0, b_ovf}, 0);
        check("rst_wdog", {31'd0, wdog_err}, 0);
        rst_n = 1'b1;

        // Single byte
        drive(1, 8'h5A, 0, 8'h00); n = cyc;
        push(8'h5A, 2'b01, n + 2, 0);
        drive(0, 8'h00, 0, 8'h00);
        wait_drain("single");
        check("single_tx_en_low", {31'd0, tx_en}, 0);

        // Tie after reset: A wins, then B
        do_reset();
        drive(1, 8'h11, 1, 8'h22); n = cyc;
        push(8'h11, 2'b01, n + 2, 0);
        push(8'h22, 2'b10, -1, 1);
        drive(0, 8'h00, 0, 8'h00);
        wait_drain("tie");

        // Burst fairness: 20 A bytes, 3 B bytes
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(8'h40 + i), i < 3, 8'(8'hB0 + i));
            if (i == 0) begin
                n = cyc;
                push(8'h40, 2'b01, n + 2, 0);
                for (int k = 1; k < 8; k++) push(8'(8'h40 + k), 2'b01, -1, 1);
                for (int k = 0; k < 3; k++) push(8'(8'hB0 + k), 2'b10, -1, 1);
                for (int k = 8; k < 20; k++) push(8'(8'h40 + k), 2'b01, -1, 1);
            end
        end
        drive(0, 8'h00, 0, 8'h00);
        wait_drain("burst");
        check("burst_no_ovf", a_ovf_cnt + b_ovf_cnt, 0);

        // Overflow: 18 writes with tx_done withheld, then full-plus-pop
        do_reset();
        done_hold = 1'b1; done_delay = 1; first_ovf_cyc = -1; base = a_ovf_cnt;
        for (int i = 0; i < 18; i++) begin
            drive(1, 8'(8'h30 + i), 0, 8'h00);
            if (i == 0) n = cyc;
            if (i <= 16) push(8'(8'h30 + i), 2'b01, (i == 0) ? n + 2 : -1, i != 0);
        end
        drive(1, 8'h99, 0, 8'h00);
        done_hold = 1'b0;
        push(8'h99, 2'b01, -1, 1);
        drive(0, 8'h00, 0, 8'h00);
        done_hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("ovf_cycle", first_ovf_cyc, n + 18);
        check("ovf_count_held", a_ovf_cnt - base, 1);
        done_delay = 2; done_hold = 1'b0;
        wait_drain("ovf");
        check("ovf_count_final", a_ovf_cnt - base, 1);
        check("b_ovf_none", b_ovf_cnt, 0);

        // Reset mid-WAIT while B owns the link
        do_reset();
        done_hold = 1'b1; done_delay = 3;
        drive(0, 8'h00, 1, 8'hC1); n = cyc;
        push(8'hC1, 2'b10, n + 2, 0);
        drive(0, 8'h00, 1, 8'hC2);
        drive(0, 8'h00, 1, 8'hC3);
        drive(0, 8'h00, 0, 8'h00);
        repeat (4) @(posedge clk);
        #1 check("mid_grant_b", {30'd0, grant}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_en", {31'd0, tx_en}, 0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 0);
        check("mid_rst_grant", {30'd0, grant}, 0);
        check("mid_rst_ovf", {30'd0, a_ovf, b_ovf}, 0);
        expq.delete();
        base = txen_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; done_hold = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_rst_no_tx_en", txen_cnt - base, 0);
        check("mid_rst_idle_grant", {30'd0, grant}, 0);

`ifdef TX_WATCHDOG_EN
        // Watchdog: withhold tx_done, next byte follows the timeout
        do_reset();
        done_hold = 1'b1; first_wdog_cyc = -1; base = wdog_cnt;
        drive(1, 8'hD1, 0, 8'h00); n = cyc;
        push(8'hD1, 2'b01, n + 2, 0);
        push(8'hD2, 2'b01, n + 103, 0);
        drive(1, 8'hD2, 0, 8'h00);
        drive(0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 200 && first_wdog_cyc < 0; i++) @(posedge clk);
        #1;
        check("wdog_cycle", first_wdog_cyc, n + 102);
        repeat (4) @(posedge clk);
        done_hold = 1'b0;
        wait_drain("wdog");
        check("wdog_count", wdog_cnt - base, 1);
`else
        check("wdog_never", wdog_cnt, 0);
`endif

        check("final_queue", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
